// File: rtl/nibble_add_sched_if.sv
// Request/response bundle for the nibble add scheduler: two add requesters
// and one result consumer. The scheduler connects through the slave modport.
interface nibble_add_sched_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/nibble_add_sched.sv
// Multi-precision adder sharing one 4-bit slice between two round-robin
// requesters; one nibble per cycle, LSB first, result held until consumed.
module nibble_add_sched #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  nibble_add_sched_if.slave bus
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic                    ptr;
  logic [IDX_W-1:0]        idx;
  logic                    carry;
  logic                    id_q;
  logic [NIBBLES-1:0][3:0] a_q;
  logic [NIBBLES-1:0][3:0] b_q;
  logic [NIBBLES-1:0][3:0] sum_q;
  logic                    rsp_valid_q;
  logic                    cout_q;
  logic                    ovf_q;

  logic       grant;
  logic       ready0;
  logic       ready1;
  logic       accept;
  logic [4:0] slice;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant = ptr;
    if (bus.req0_valid && !bus.req1_valid) grant = 1'b0;
    else if (bus.req1_valid && !bus.req0_valid) grant = 1'b1;
  end

  // Ready is held low while reset is asserted so nothing looks accepted.
  assign ready0 = (state == IDLE) && !rst && bus.req0_valid && !grant;
  assign ready1 = (state == IDLE) && !rst && bus.req1_valid && grant;
  assign accept = ready0 || ready1;

  assign slice = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {4'b0000, carry};

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_sum    = sum_q;
  assign bus.rsp_cout   = cout_q;
  assign bus.rsp_ovf    = ovf_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      idx         <= '0;
      carry       <= 1'b0;
      id_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= grant ? bus.req1_a : bus.req0_a;
            b_q   <= grant ? bus.req1_b : bus.req0_b;
            carry <= grant ? bus.req1_cin : bus.req0_cin;
            id_q  <= grant;
            idx   <= '0;
            ptr   <= ~grant;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= slice[3:0];
          carry      <= slice[4];
          if (idx == IDX_LAST) begin
            // Wrap idx here so it never indexes past the top nibble.
            idx         <= '0;
            cout_q      <= slice[4];
            ovf_q       <= (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                           (slice[3] != a_q[NIBBLES-1][3]);
            rsp_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_sched.sv
// Self-checking bench for nibble_add_sched: a 4-nibble and a 1-nibble
// instance, checked against a plain-arithmetic add model.
`timescale 1ns/1ps
module tb_nibble_add_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_add_sched_if #(.NIBBLES(4)) b4 ();
  nibble_add_sched_if #(.NIBBLES(1)) b1 ();

  nibble_add_sched #(.NIBBLES(4)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  nibble_add_sched #(.NIBBLES(1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Returns {ovf, cout, sum} for a w-bit add of a + b + cin.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic [15:0] mask;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    mask = 16'((17'd1 << w) - 17'd1);
    full = 17'(a & mask) + 17'(b & mask) + 17'(cin);
    sum  = full[15:0] & mask;
    cout = full[w];
    ovf  = (a[w-1] == b[w-1]) && (sum[w-1] != a[w-1]);
    return {ovf, cout, sum};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic cin);
    if (id == 0) begin
      b4.req0_valid = v; b4.req0_a = a; b4.req0_b = b; b4.req0_cin = cin;
    end else begin
      b4.req1_valid = v; b4.req1_a = a; b4.req1_b = b; b4.req1_cin = cin;
    end
  endtask

  function automatic logic ready_of(input int id);
    return (id == 0) ? b4.req0_ready : b4.req1_ready;
  endfunction

  // Drives one add on the 4-nibble instance and reports what came back.
  task automatic do_txn(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output logic [18:0] got,
                        output int lat, output bit tmo);
    int guard;
    tmo = 1'b0;
    lat = 0;
    guard = 0;
    b4.rsp_ready = 1'b1;
    set_req(id, 1'b1, a, b, cin);
    #1;
    while (!ready_of(id) && guard < 20) begin
      tick();
      guard++;
    end
    if (!ready_of(id)) tmo = 1'b1;
    tick();
    set_req(id, 1'b0, 16'($urandom), 16'($urandom), 1'b0);
    while (!b4.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!b4.rsp_valid) tmo = 1'b1;
    got = {b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    n_checks++; if (b4.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", b4.rsp_valid); end
    n_checks++; if (b4.rsp_sum !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_sum: got %h expected 0000", b4.rsp_sum); end
    n_checks++; if ({b4.rsp_id, b4.rsp_cout, b4.rsp_ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {b4.rsp_id, b4.rsp_cout, b4.rsp_ovf}); end
    n_checks++; if (b1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_n1_valid: got %b expected 0", b1.rsp_valid); end
    tick();
    rst = 1'b0;
    b4.req1_valid = 1'b1;
    #1;
    n_checks++; if ({b4.req0_ready, b4.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL grant_only1: got %b expected 01", {b4.req0_ready, b4.req1_ready}); end
    b4.req0_valid = 1'b1;
    #1;
    n_checks++; if ({b4.req0_ready, b4.req1_ready} !== 2'b10) begin n_fail++; $display("FAIL grant_both_ptr0: got %b expected 10", {b4.req0_ready, b4.req1_ready}); end
    b4.req0_valid = 1'b0;
    b4.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic        tc [4];
    int          tid[4];
    logic [18:0] got;
    logic [18:0] exp;
    int          lat;
    bit          tmo;
    ta  = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000};
    tb  = '{16'h0001, 16'h0001, 16'h0000, 16'h8000};
    tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tid = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      exp = {tid[i][0], ref_add(16, ta[i], tb[i], tc[i])};
      do_txn(tid[i], ta[i], tb[i], tc[i], got, lat, tmo);
      n_checks++; if (tmo || lat != 4) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d (timeout %0d) expected 4", i, lat, tmo); end
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL directed_result[%0d]: got id/ovf/cout/sum %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    int          id;
    logic [18:0] got;
    logic [18:0] exp;
    int          lat;
    bit          tmo;
    for (int i = 0; i < 16; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      c  = 1'($urandom);
      id = int'($urandom_range(1, 0));
      exp = {id[0], ref_add(16, a, b, c)};
      do_txn(id, a, b, c, got, lat, tmo);
      n_checks++; if (tmo || lat != 4) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d (timeout %0d) expected 4", i, lat, tmo); end
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL random_result[%0d]: got %h expected %h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a0, b0v, a1, b1v;
    logic        c0, c1;
    logic [18:0] expq[$];
    logic [18:0] exp;
    logic        gid;
    int          exp_ptr, last_acc, n_acc, n_rsp, chg;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    b4.rsp_ready = 1'b1;
    a0 = 16'($urandom); b0v = 16'($urandom); c0 = 1'($urandom);
    a1 = 16'($urandom); b1v = 16'($urandom); c1 = 1'($urandom);
    set_req(0, 1'b1, a0, b0v, c0);
    set_req(1, 1'b1, a1, b1v, c1);
    exp_ptr = 0; last_acc = 0; n_acc = 0; n_rsp = 0;
    for (int cyc = 0; cyc < 80 && n_rsp < 4; cyc++) begin
      #1;
      chg = -1;
      n_checks++; if (b4.req0_ready && b4.req1_ready) begin n_fail++; $display("FAIL b2b_both_ready: got 11 expected at most one ready at cycle %0d", cyc); end
      if (b4.req0_ready || b4.req1_ready) begin
        gid = b4.req1_ready;
        n_checks++; if (int'(gid) != exp_ptr) begin n_fail++; $display("FAIL b2b_grant_order: got id %0d expected %0d", gid, exp_ptr); end
        if (n_acc > 0) begin
          n_checks++; if (cyc - last_acc != 6) begin n_fail++; $display("FAIL b2b_interval: got %0d cycles expected 6", cyc - last_acc); end
        end
        expq.push_back(gid ? {1'b1, ref_add(16, a1, b1v, c1)} : {1'b0, ref_add(16, a0, b0v, c0)});
        exp_ptr = 1 - int'(gid);
        last_acc = cyc;
        n_acc++;
        chg = int'(gid);
      end
      if (b4.rsp_valid) begin
        n_rsp++;
        if (expq.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL b2b_spurious_rsp: got rsp %h expected none", b4.rsp_sum);
        end else begin
          exp = expq.pop_front();
          n_checks++; if ({b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum} !== exp) begin n_fail++; $display("FAIL b2b_result: got %h expected %h", {b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum}, exp); end
        end
      end
      tick();
      if (n_acc >= 4) begin
        b4.req0_valid = 1'b0;
        b4.req1_valid = 1'b0;
      end else if (chg == 0) begin
        a0 = 16'($urandom); b0v = 16'($urandom); c0 = 1'($urandom);
        set_req(0, 1'b1, a0, b0v, c0);
      end else if (chg == 1) begin
        a1 = 16'($urandom); b1v = 16'($urandom); c1 = 1'($urandom);
        set_req(1, 1'b1, a1, b1v, c1);
      end
    end
    n_checks++; if (n_acc != 4 || n_rsp != 4) begin n_fail++; $display("FAIL b2b_count: got %0d accepts %0d responses expected 4 and 4", n_acc, n_rsp); end
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b;
    logic        c;
    logic [17:0] exp;
    logic [17:0] exp1;
    int          guard;
    a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
    exp  = ref_add(16, a, b, c);
    exp1 = ref_add(16, 16'hA5A5, 16'h5A5B, 1'b1);
    b4.rsp_ready = 1'b0;
    set_req(0, 1'b1, a, b, c);
    #1;
    guard = 0;
    while (!b4.req0_ready && guard < 20) begin tick(); guard++; end
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    guard = 0;
    while (!b4.rsp_valid && guard < 20) begin tick(); guard++; end
    n_checks++; if (!b4.rsp_valid) begin n_fail++; $display("FAIL bp_rsp_timeout: got rsp_valid 0 expected 1"); end
    set_req(1, 1'b1, 16'hA5A5, 16'h5A5B, 1'b1);
    #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({b4.rsp_valid, b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum} !== {2'b10, exp}) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h expected %h", i, {b4.rsp_valid, b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum}, {2'b10, exp}); end
      n_checks++; if ({b4.req0_ready, b4.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready_low[%0d]: got %b expected 00", i, {b4.req0_ready, b4.req1_ready}); end
      tick();
    end
    b4.rsp_ready = 1'b1;
    tick();
    n_checks++; if ({b4.rsp_valid, b4.req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got valid/ready1 %b expected 01", {b4.rsp_valid, b4.req1_ready}); end
    tick();
    set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
    guard = 0;
    while (!b4.rsp_valid && guard < 20) begin tick(); guard++; end
    n_checks++; if (guard != 4 || {b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum} !== {1'b1, exp1}) begin n_fail++; $display("FAIL bp_next: got latency %0d result %h expected 4 and %h", guard, {b4.rsp_id, b4.rsp_ovf, b4.rsp_cout, b4.rsp_sum}, {1'b1, exp1}); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [18:0] got;
    int          lat;
    bit          tmo;
    int          seen;
    int          guard;
    b4.rsp_ready = 1'b1;
    set_req(0, 1'b1, 16'h3C3C, 16'h1111, 1'b0);
    #1;
    guard = 0;
    while (!b4.req0_ready && guard < 20) begin tick(); guard++; end
    tick();
    set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++; if ({b4.rsp_valid, b4.rsp_id, b4.rsp_cout, b4.rsp_ovf, b4.rsp_sum} !== 20'h0) begin n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 00000", {b4.rsp_valid, b4.rsp_id, b4.rsp_cout, b4.rsp_ovf, b4.rsp_sum}); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (b4.rsp_valid) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrun_no_response: got %0d valid cycles expected 0", seen); end
    do_txn(0, 16'h1234, 16'h1111, 1'b0, got, lat, tmo);
    n_checks++; if (tmo || lat != 4 || got !== {1'b0, 18'(ref_add(16, 16'h1234, 16'h1111, 1'b0))} || got[15:0] !== 16'h2345) begin n_fail++; $display("FAIL midrun_fresh: got %h latency %0d expected sum 2345 latency 4", got, lat); end
  endtask

  task automatic test_nibbles1();
    logic [3:0]  a, b;
    logic        c;
    logic [17:0] exp;
    int          lat;
    int          guard;
    b1.rsp_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin a = 4'hF; b = 4'h1; c = 1'b1; end
      else begin a = 4'($urandom); b = 4'($urandom); c = 1'($urandom); end
      exp = ref_add(4, {12'h0, a}, {12'h0, b}, c);
      if (i == 0) begin
        n_checks++; if (exp !== {1'b0, 1'b1, 16'h0001}) begin n_fail++; $display("FAIL n1_model: got %h expected 0x10001", exp); end
      end
      b1.req0_valid = 1'b1; b1.req0_a = a; b1.req0_b = b; b1.req0_cin = c;
      #1;
      guard = 0;
      while (!b1.req0_ready && guard < 20) begin tick(); guard++; end
      tick();
      b1.req0_valid = 1'b0;
      lat = 0;
      while (!b1.rsp_valid && lat < 20) begin tick(); lat++; end
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL n1_latency[%0d]: got %0d expected 1", i, lat); end
      n_checks++; if ({b1.rsp_id, b1.rsp_ovf, b1.rsp_cout, b1.rsp_sum} !== {1'b0, exp[17:16], exp[3:0]}) begin n_fail++; $display("FAIL n1_result[%0d]: got %h expected %h", i, {b1.rsp_id, b1.rsp_ovf, b1.rsp_cout, b1.rsp_sum}, {1'b0, exp[17:16], exp[3:0]}); end
      tick();
    end
  endtask

  initial begin
    b4.rsp_ready = 1'b1;
    b1.rsp_ready = 1'b1;
    b1.req0_valid = 1'b0; b1.req0_a = 4'h0; b1.req0_b = 4'h0; b1.req0_cin = 1'b0;
    b1.req1_valid = 1'b0; b1.req1_a = 4'h0; b1.req1_b = 4'h0; b1.req1_cin = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_nibbles1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
